sseg_display_mux: RTL and testbench
===================================

# sseg_display_mux

Parametrised, time-multiplexed seven-segment display controller for the OTTER board wrapper. It drives a configurable number of digits with hex or unsigned-decimal rendering. Decimal rendering uses an iterative binary-to-BCD converter. The block also provides per-digit decimal points, optional leading-zero blanking and an overflow indication. It sits between the OTTER MMIO output register and the board's CATHODES/ANODES pins.

## Interface
Parameters:
- DIGITS, 4: number of digits; legal range 1..8.
- REFRESH_DIV, 50000: CLK cycles each digit stays enabled; minimum 1.

Ports (W = 4*DIGITS):
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, synchronous, active-high.
- DATA  in  W  value to display; in hex mode, nibble i is digit i; in decimal mode, unsigned binary.
- MODE  in  1  0 = hex, 1 = decimal.
- DP_MASK  in  DIGITS  bit i lights the decimal point of digit i.
- BLANK_LZ  in  1  1 = blank leading zero digits.
- LOAD  in  1  single-cycle strobe that captures DATA/MODE/DP_MASK/BLANK_LZ.
- BUSY  out  1  high while a decimal conversion is running.
- CATHODES  out  8  active-low segments: [7]=dp, [6]=g, [5]=f, [4]=e, [3]=d, [2]=c, [1]=b, [0]=a.
- ANODES  out  DIGITS  active-low digit enables; ANODES[0] is the least-significant digit.

## Operation
- Shadow registers hold 4-bit code, blank flag and dp flag for each digit. The scan logic reads only these registers.
- LOAD is accepted only when BUSY=0. LOAD while BUSY=1 is ignored with no side effect.
- Hex mode: the shadow registers take the new value at the accepting edge. BUSY stays low.
- Decimal mode: the converter runs a double-dabble over W input bits into DIGITS+2 BCD digits.
  - If either of the top two BCD digits is nonzero, the result is an overflow. Every digit then shows a dash (g only). Blanking is suppressed and dp still follows DP_MASK.
  - Otherwise the low DIGITS BCD digits are committed to the shadow registers.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blank when it and all higher digits are zero. Digit 0 is never blanked.
- A blank digit drives CATHODES[6:0]=all ones. Its dp still follows DP_MASK.
- Scan: prescaler counts 0..REFRESH_DIV-1. At terminal count it resets, and the digit index advances, wrapping from DIGITS-1 to 0.
- CATHODES and ANODES are registered from the digit index and the shadow registers. Exactly one anode is low outside reset.

## Timing
- Reset values:
  - ANODES = all ones, CATHODES = 8'hFF, BUSY = 0.
  - Shadow codes = 0, blank flags = 0, dp flags = 0, MODE shadow = 0.
  - Prescaler = 0, digit index = 0.
- First cycle after RST falls: ANODES[0] low, CATHODES = 8'hC0 ('0').
- Each digit stays enabled for exactly REFRESH_DIV cycles. Outputs change one cycle after the index changes.
- Hex LOAD accepted at edge t: new shadow contents are visible from cycle t+1. They reach CATHODES at the next output register update (cycle t+2 at the earliest).
- Decimal LOAD accepted at edge t:
  - BUSY is high for cycles t+1..t+W (W shift cycles).
  - The shadow registers update and BUSY falls at cycle t+W+1.
  - A new LOAD is accepted at t+W+1.
- The update is atomic. The scan never shows a mix of old and new digits.
- RST during conversion aborts it: BUSY=0 next cycle, the shadow registers return to 0, and the input is discarded.

## Structure
- Package sseg_pkg:
  - seg_encode function: nibble to 7-bit active-low pattern, 0-F.
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - bcd_digits(DIGITS) = DIGITS+2.
- Sub-module bin2bcd_seq: parametrised on input width W. It has start/busy/done handshake, performs the shift-add-3 per cycle, and returns DIGITS+2 BCD digits.
- Top level contains: LOAD arbitration, shadow registers, blanking logic, prescaler, digit index, output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset and scan: hold RST 3 cycles -> ANODES=4'hF, CATHODES=8'hFF, BUSY=0. After release, ANODES cycles 4'hE, D, B, 7, each for 4 cycles, then wraps to E. Every CATHODES value is 8'hC0.
- Hex: LOAD DATA=16'hBEEF, MODE=0, DP_MASK=0 -> BUSY stays 0. Digit 0 shows 8'h8E ('F'), digit 2 shows 8'h86 ('E'). DP_MASK=4'b0001 gives digit 0 = 8'h0E.
- Decimal: LOAD DATA=16'd1234, MODE=1 -> BUSY high exactly 16 cycles. Digits 0..3 then show 8'h99, 8'hB0, 8'hA4, 8'hF9 ('4','3','2','1').
- Overflow: decimal LOAD DATA=16'd12345 -> after BUSY falls, all four digits show 8'hBF. Decimal 16'd9999 shows 8'h90 on every digit.
- Blanking: hex LOAD 16'h0007 with BLANK_LZ=1 -> digit 0 = 8'hF8, digits 1..3 = 8'hFF. LOAD 16'h0000 -> digit 0 = 8'hC0.
- Busy and abort:
  - LOAD hex 16'h1111 while BUSY -> ignored; the decimal result still commits.
  - RST asserted at shift cycle 8 -> BUSY=0 and all digits show 8'hC0 after release.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment display controller.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Converter width: two spare BCD digits expose values too large to display.
  function automatic int bcd_digits(input int digits);
    return digits + 2;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock over W input bits.
// done pulses on the final step with the finished result on bcd.
module bin2bcd_seq #(
  parameter int W    = 16,
  parameter int NBCD = 6
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [W-1:0]      din,
  output logic              busy,
  output logic              done,
  output logic [4*NBCD-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]      sh_reg;
  logic [4*NBCD-1:0] bcd_reg;
  logic [4*NBCD-1:0] bcd_next;
  logic [4*NBCD-2:0] adj;
  logic [CW-1:0]     cnt_reg;
  logic              busy_reg;

  // The top digit's carry-out is dropped: NBCD digits always cover W bits.
  for (genvar gi = 0; gi < NBCD; gi++) begin : g_adj
    logic ge5;
    assign ge5 = (bcd_reg[4*gi +: 4] >= 4'd5);
    if (gi < NBCD - 1) begin : g_full
      assign adj[4*gi +: 4] = ge5 ? bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end else begin : g_top
      assign adj[4*gi +: 3] = bcd_reg[4*gi +: 3] + (ge5 ? 3'd3 : 3'd0);
    end
  end

  assign bcd_next = {adj, sh_reg[W-1]};

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      sh_reg   <= '0;
      bcd_reg  <= '0;
    end else if (start && !busy_reg) begin
      busy_reg <= 1'b1;
      cnt_reg  <= CW'(W);
      sh_reg   <= din;
      bcd_reg  <= '0;
    end else if (busy_reg) begin
      sh_reg   <= sh_reg << 1;
      bcd_reg  <= bcd_next;
      cnt_reg  <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) busy_reg <= 1'b0;
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == CW'(1));
  assign bcd  = bcd_next;

endmodule

// File: rtl/sseg_display_mux.sv
// Time-multiplexed seven-segment controller with hex or decimal rendering.
// The scan reads only the shadow registers, which update atomically.
module sseg_display_mux
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic                  MODE,
  input  logic [DIGITS-1:0]     DP_MASK,
  input  logic                  BLANK_LZ,
  input  logic                  LOAD,
  output logic                  BUSY,
  output logic [7:0]            CATHODES,
  output logic [DIGITS-1:0]     ANODES
);

  localparam int W    = 4 * DIGITS;
  localparam int NBCD = bcd_digits(DIGITS);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic              conv_busy;
  logic              conv_done;
  logic [4*NBCD-1:0] conv_bcd;
  logic              accept;
  logic              start;

  logic [DIGITS-1:0][3:0] code_reg;
  logic [DIGITS-1:0]      blank_reg;
  logic [DIGITS-1:0]      dp_reg;
  logic                   mode_reg;
  logic                   ovf_reg;
  logic [DIGITS-1:0]      dp_pend_reg;
  logic                   blz_pend_reg;

  logic [DIGITS-1:0][3:0] new_codes;
  logic [DIGITS-1:0]      new_blank;
  logic                   new_blz;
  logic                   nz;
  logic                   ovf_new;

  logic [PW-1:0]     presc_reg;
  logic [IW-1:0]     idx_reg;
  logic [DIGITS-1:0] anodes_reg;
  logic [7:0]        cathodes_reg;
  logic [6:0]        seg_cur;

  assign accept = LOAD && !conv_busy;
  assign start  = accept && MODE;

  bin2bcd_seq #(.W(W), .NBCD(NBCD)) u_conv (
    .clk   (CLK),
    .srst  (RST),
    .start (start),
    .din   (DATA),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Blank flags for whichever value is about to be committed.
  always_comb begin
    new_codes = conv_done ? conv_bcd[W-1:0] : DATA;
    new_blz   = conv_done ? blz_pend_reg : BLANK_LZ;
    new_blank = '0;
    nz        = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz           = nz | (new_codes[i] != 4'd0);
      new_blank[i] = new_blz && (i != 0) && !nz;
    end
    ovf_new = |conv_bcd[4*NBCD-1:W];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      code_reg     <= '0;
      blank_reg    <= '0;
      dp_reg       <= '0;
      mode_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      dp_pend_reg  <= '0;
      blz_pend_reg <= 1'b0;
    end else if (accept && !MODE) begin
      code_reg  <= DATA;
      blank_reg <= new_blank;
      dp_reg    <= DP_MASK;
      mode_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (start) begin
      dp_pend_reg  <= DP_MASK;
      blz_pend_reg <= BLANK_LZ;
    end else if (conv_done) begin
      code_reg  <= ovf_new ? '0 : conv_bcd[W-1:0];
      blank_reg <= ovf_new ? '0 : new_blank;
      dp_reg    <= dp_pend_reg;
      mode_reg  <= 1'b1;
      ovf_reg   <= ovf_new;
    end
  end

  always_comb begin
    seg_cur = seg_encode(code_reg[idx_reg]);
    if (blank_reg[idx_reg]) seg_cur = SEG_BLANK;
    if (mode_reg && ovf_reg) seg_cur = SEG_DASH;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg    <= '0;
      idx_reg      <= '0;
      anodes_reg   <= '1;
      cathodes_reg <= 8'hFF;
    end else begin
      if (presc_reg == PW'(REFRESH_DIV - 1)) begin
        presc_reg <= '0;
        idx_reg   <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      anodes_reg   <= ~(DIGITS'(1) << idx_reg);
      cathodes_reg <= {~dp_reg[idx_reg], seg_cur};
    end
  end

  assign BUSY     = conv_busy;
  assign ANODES   = anodes_reg;
  assign CATHODES = cathodes_reg;

endmodule

// File: tb/tb_sseg_display_mux.sv
// Directed bench for sseg_display_mux (DIGITS=4, REFRESH_DIV=4).
// Expected per-digit cathodes are queued at each load and checked over a full scan.
module tb_sseg_display_mux;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DATA = '0;
  logic        MODE = 1'b0;
  logic [3:0]  DP_MASK = '0;
  logic        BLANK_LZ = 1'b0;
  logic        LOAD = 1'b0;
  logic        BUSY;
  logic [7:0]  CATHODES;
  logic [3:0]  ANODES;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  sseg_display_mux #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA     (DATA),
    .MODE     (MODE),
    .DP_MASK  (DP_MASK),
    .BLANK_LZ (BLANK_LZ),
    .LOAD     (LOAD),
    .BUSY     (BUSY),
    .CATHODES (CATHODES),
    .ANODES   (ANODES)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic do_load(input logic [15:0] d, input logic m,
                         input logic [3:0] dp, input logic blz);
    DATA = d; MODE = m; DP_MASK = dp; BLANK_LZ = blz; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic wait_busy(input string tag, input int expected_len);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK);
    end
    chk(tag, 32'(n), 32'(expected_len));
  endtask

  task automatic check_scan(input string tag);
    logic [7:0] e[4];
    logic [3:0] prev;
    logic [3:0] ea;
    int n;
    for (int i = 0; i < 4; i++) e[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    prev = ANODES;
    n = 0;
    @(negedge CLK);
    while (!(ANODES === 4'hE && prev !== 4'hE) && n < 40) begin
      prev = ANODES;
      @(negedge CLK);
      n++;
    end
    chk({tag, "_sync"}, 32'(n < 40), 32'd1);
    for (int d = 0; d < 4; d++) begin
      ea = ~(4'b0001 << d);
      for (int c = 0; c < 4; c++) begin
        if (d != 0 || c != 0) @(negedge CLK);
        chk({tag, "_anodes"}, 32'(ANODES), 32'(ea));
        chk({tag, "_cathodes"}, 32'(CATHODES), 32'(e[d]));
      end
    end
    @(negedge CLK);
    chk({tag, "_wrap"}, 32'(ANODES), 32'h0000000E);
    $display("scan %s: digits3..0 = %h %h %h %h", tag, e[3], e[2], e[1], e[0]);
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_anodes", 32'(ANODES), 32'h0000000F);
    chk("reset_cathodes", 32'(CATHODES), 32'h000000FF);
    chk("reset_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    push4(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check_scan("reset_scan");

    // Hex without and with decimal point on digit 0
    do_load(16'hBEEF, 1'b0, 4'b0000, 1'b0);
    chk("hex_busy", 32'(BUSY), 32'd0);
    push4(8'h8E, 8'h86, 8'h86, 8'h83);
    check_scan("hex_beef");
    do_load(16'hBEEF, 1'b0, 4'b0001, 1'b0);
    chk("hex_dp_busy", 32'(BUSY), 32'd0);
    push4(8'h0E, 8'h86, 8'h86, 8'h83);
    check_scan("hex_beef_dp");

    // Decimal 1234
    do_load(16'd1234, 1'b1, 4'b0000, 1'b0);
    wait_busy("dec1234_busy_len", 16);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
    check_scan("dec_1234");

    // Overflow: dashes, blanking suppressed, dp on digit 2 still lit
    do_load(16'd12345, 1'b1, 4'b0100, 1'b1);
    wait_busy("dec12345_busy_len", 16);
    push4(8'hBF, 8'hBF, 8'h3F, 8'hBF);
    check_scan("dec_overflow");

    do_load(16'd9999, 1'b1, 4'b0000, 1'b0);
    wait_busy("dec9999_busy_len", 16);
    push4(8'h90, 8'h90, 8'h90, 8'h90);
    check_scan("dec_9999");

    // Leading-zero blanking, dp on a blank digit
    do_load(16'h0007, 1'b0, 4'b1000, 1'b1);
    push4(8'hF8, 8'hFF, 8'hFF, 8'h7F);
    check_scan("blank_0007");
    do_load(16'h0000, 1'b0, 4'b0000, 1'b1);
    push4(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    check_scan("blank_0000");

    // Hex LOAD during conversion is ignored
    do_load(16'd1234, 1'b1, 4'b0000, 1'b0);
    repeat (3) @(negedge CLK);
    do_load(16'h1111, 1'b0, 4'b1111, 1'b0);
    chk("ignored_load_busy", 32'(BUSY), 32'd1);
    wait_busy("ignored_load_remaining", 12);
    push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
    check_scan("busy_ignore");

    // Reset at shift cycle 8 aborts and clears the shadows
    do_load(16'd4321, 1'b1, 4'b0000, 1'b0);
    repeat (7) @(negedge CLK);
    chk("abort_busy_before", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_anodes", 32'(ANODES), 32'h0000000F);
    RST = 1'b0;
    push4(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check_scan("abort_scan");
    chk("abort_busy_after", 32'(BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
